useq_progmem_loader: RTL and testbench
======================================

// Module: useq_progmem_loader
// PURPOSE
//  Program-memory responder for the 8-bit micro-sequencer fetch port: 256x8 RAM answering mem_addr with mem_data.
//  Also a framed byte-stream loader that writes programs into the RAM.
//  Holds the sequencer in reset (core_rst_n) while a program is being loaded.
//  Sits between a byte source (UART RX, SPI slave) and the sequencer's mem_addr/mem_data/rst_n pins.
// PARAMETERS
//  SYNC_BYTE  8'hA5  frame start marker
//  BOOT_HOLD  4      cycles core_rst_n stays low after a good frame (1..255)
// PORTS
//  clk          in   1  clock
//  rst_n        in   1  reset, synchronous, active-low
//  in_data      in   8  loader byte
//  in_valid     in   1  in_data valid; byte accepted when in_valid && in_ready at posedge clk
//  in_ready     out  1  loader can accept a byte
//  mem_addr     in   8  sequencer fetch address (registered in the core)
//  mem_data     out  8  RAM[mem_addr], combinational (core samples the cycle after it drives mem_addr)
//  core_rst_n   out  1  sequencer reset, active-low
//  busy         out  1  frame in progress or hold countdown active
//  err          out  1  sticky checksum error
// BEHAVIOUR
//  Reset values: in_ready=0 during rst_n=0, then 1; core_rst_n=0; busy=0; err=0; FSM=IDLE.
//  RAM contents are not reset and persist across rst_n.
//  Core is never released before the first good frame.
//  Frame format: SYNC_BYTE, ADDR, LEN, LEN data bytes, CSUM.
//  LEN=0 means 256 bytes.
//  Checksum rule: (ADDR+LEN+sum(data)+CSUM) mod 256 == 0.
//  FSM states and transitions:
//   IDLE: non-SYNC bytes discarded. SYNC -> ADDR; core_rst_n<=0, busy<=1, err<=0, cnt<=0.
//   ADDR: ptr<=byte, sum<=byte -> LEN.
//   LEN: remaining<={byte==0,byte}, a 9-bit count; sum+=byte -> DATA.
//   DATA: per accepted byte: RAM[ptr]<=byte, ptr<=ptr+1 (wraps 8'hFF->8'h00), sum+=byte.
//     Last byte -> CSUM.
//   CSUM: (sum+byte)==0 -> HOLD, else err<=1, busy<=0 -> IDLE with core_rst_n still 0.
//   HOLD: in_ready=0. Counts BOOT_HOLD cycles, then core_rst_n<=1, busy<=0 -> IDLE.
//  in_ready=1 in every state except HOLD. No internal stalls, so one byte per cycle is sustained.
//  RAM write is synchronous.
//  Read is asynchronous: a write to the currently addressed location is visible on mem_data the cycle after the write edge.
//  SYNC_BYTE value inside ADDR/LEN/DATA/CSUM is plain data; no resync.
//  A mid-frame rst_n returns FSM to IDLE with core_rst_n=0. Bytes already written stay in RAM; no rollback.
//  Back-to-back frames: a SYNC accepted in IDLE right after HOLD re-asserts core reset on the next edge.
// CONFIGURATION
//  USEQ_LDR_CSUM_EN defined: CSUM state and err behave as above.
//  Undefined: no CSUM byte in the frame; the last DATA byte -> HOLD directly; err tied 0; sum logic removed.
// STRUCTURE
//  useq_pkg.vh holds shared constants:
//   loader state encodings (IDLE/ADDR/LEN/DATA/CSUM/HOLD, 3 bits)
//   default SYNC_BYTE
//   fetch-port widths (ADDR_W=8, DATA_W=8)
//  Sub-module useq_ram256: 256x8 RAM, synchronous write (we, waddr, wdata), asynchronous read (raddr->rdata).
//  The top level holds FSM, pointer, 9-bit remaining counter, sum, hold counter.
// TESTING
//  1. Frame A5 00 03 B1 10 D0 6C -> RAM[0..2]=B1,10,D0; err=0; core_rst_n rises BOOT_HOLD cycles after CSUM accept.
//  2. Same frame with CSUM 6D -> err=1, core_rst_n=0, busy=0; then repeat with 6C -> err clears on SYNC, core released.
//  3. A5 FE 04 11 22 33 44 CSUM=(-(FE+04+AA))=54 -> RAM[FE,FF,00,01]=11,22,33,44 (wrap).
//  4. A5 00 00 + 256 bytes i -> RAM[i]=i for all i, then correct CSUM.
//     Also drive mem_addr 0..FF and check mem_data=i combinationally.
//  5. Bytes 00 FF 5A before SYNC -> ignored, no RAM write. in_valid held high through HOLD -> in_ready=0, no byte lost.
//  6. rst_n low after 2 of 3 DATA bytes -> core_rst_n=0, FSM IDLE, those 2 bytes persist. Next good frame completes normally.

Source files
------------

// File: rtl/useq_progmem_loader_pkg.sv
// Shared constants for the micro-sequencer program-memory loader:
// fetch-port widths, default frame marker and loader state encodings.
package useq_progmem_loader_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_HOLD = 3'd5
  } ldr_state_e;

endpackage

// File: rtl/useq_progmem_loader_ram256.sv
// 256x8 program RAM: synchronous write port for the loader, asynchronous
// read port for the sequencer fetch path. Contents are never reset.
module useq_ram256
  import useq_progmem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [256];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/useq_progmem_loader.sv
// Program-memory responder plus framed byte-stream loader; holds the core in
// reset while loading. Define USEQ_LDR_CSUM_EN to add the trailing checksum byte.
module useq_progmem_loader
  import useq_progmem_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         BOOT_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_core_rst_n,
  output logic              o_busy,
  output logic              o_err
);

  ldr_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [8:0]        r_rem;
  logic [7:0]        r_cnt;
  logic              r_core_rst_n;
  logic              r_busy;
  logic              w_acc;
  logic              w_we;
  logic              w_hold_done;
  logic              w_csum_ok;

  assign o_in_ready   = rst_n && (r_state != ST_HOLD);
  assign w_acc        = i_in_valid && o_in_ready;
  assign w_hold_done  = (r_cnt == 8'(BOOT_HOLD - 1));
  assign o_core_rst_n = r_core_rst_n;
  assign o_busy       = r_busy;

`ifdef USEQ_LDR_CSUM_EN
  logic [7:0] r_sum;
  logic       r_err;
  assign w_csum_ok = ((r_sum + i_in_data) == 8'h00);
  assign o_err     = r_err;
`else
  assign w_csum_ok = 1'b1;
  assign o_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    case (r_state)
      ST_IDLE: if (w_acc && i_in_data == SYNC_BYTE) w_state_nxt = ST_ADDR;
      ST_ADDR: if (w_acc) w_state_nxt = ST_LEN;
      ST_LEN:  if (w_acc) w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (w_acc) begin
          w_we = 1'b1;
`ifdef USEQ_LDR_CSUM_EN
          if (r_rem == 9'd1) w_state_nxt = ST_CSUM;
`else
          if (r_rem == 9'd1) w_state_nxt = ST_HOLD;
`endif
        end
      end
      ST_CSUM: if (w_acc) w_state_nxt = w_csum_ok ? ST_HOLD : ST_IDLE;
      ST_HOLD: if (w_hold_done) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_rem        <= '0;
      r_cnt        <= '0;
      r_core_rst_n <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc && i_in_data == SYNC_BYTE) begin
            r_core_rst_n <= 1'b0;
            r_busy       <= 1'b1;
            r_cnt        <= '0;
          end
        end
        ST_ADDR: if (w_acc) r_ptr <= i_in_data;
        // LEN of zero encodes a full 256-byte page
        ST_LEN:  if (w_acc) r_rem <= {i_in_data == 8'h00, i_in_data};
        ST_DATA: begin
          if (w_acc) begin
            r_ptr <= r_ptr + 8'd1;
            r_rem <= r_rem - 9'd1;
          end
        end
        ST_CSUM: if (w_acc && !w_csum_ok) r_busy <= 1'b0;
        ST_HOLD: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_hold_done) begin
            r_core_rst_n <= 1'b1;
            r_busy       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef USEQ_LDR_CSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else if (w_acc) begin
      case (r_state)
        ST_IDLE:         if (i_in_data == SYNC_BYTE) r_err <= 1'b0;
        ST_ADDR:         r_sum <= i_in_data;
        ST_LEN, ST_DATA: r_sum <= r_sum + i_in_data;
        ST_CSUM:         if (!w_csum_ok) r_err <= 1'b1;
        default: ;
      endcase
    end
  end
`endif

  useq_ram256 u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_ptr),
    .wdata (i_in_data),
    .raddr (i_mem_addr),
    .rdata (o_mem_data)
  );

endmodule

// File: tb/tb_useq_progmem_loader.sv
// Directed bench for useq_progmem_loader: framing, hold timing, wrap,
// full page, discard, stall-through-hold and mid-frame reset.
module tb_useq_progmem_loader;

  localparam int BOOT_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_in_data;
  logic       i_in_valid;
  logic       o_in_ready;
  logic [7:0] i_mem_addr;
  logic [7:0] o_mem_data;
  logic       o_core_rst_n;
  logic       o_busy;
  logic       o_err;

  int n_chk  = 0;
  int n_fail = 0;

  useq_progmem_loader #(.SYNC_BYTE(8'hA5), .BOOT_HOLD(BOOT_HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_in_data    (i_in_data),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_mem_addr   (i_mem_addr),
    .o_mem_data   (o_mem_data),
    .o_core_rst_n (o_core_rst_n),
    .o_busy       (o_busy),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one byte and waits (bounded) until it is accepted.
  task automatic send(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    i_in_data  = b;
    i_in_valid = 1'b1;
    while (!o_in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("send_timeout", 16'(guard), 16'd0);
    @(posedge clk);
    #1 i_in_valid = 1'b0;
  endtask

  task automatic send_csum(input logic [7:0] cs);
`ifdef USEQ_LDR_CSUM_EN
    send(cs);
`else
    if (cs === 8'hxx) $display("unused");
`endif
  endtask

  // Called right after the last frame byte is accepted.
  task automatic hold_check(input string tag);
    chk({tag, "_hold_core"}, 16'(o_core_rst_n), 16'd0);
    chk({tag, "_hold_rdy"},  16'(o_in_ready),   16'd0);
    repeat (BOOT_HOLD - 1) @(posedge clk);
    #1 chk({tag, "_pre_rel"}, 16'(o_core_rst_n), 16'd0);
    @(posedge clk);
    #1 chk({tag, "_rel_core"}, 16'(o_core_rst_n), 16'd1);
    chk({tag, "_rel_busy"}, 16'(o_busy), 16'd0);
    chk({tag, "_rel_err"},  16'(o_err),  16'd0);
  endtask

  task automatic chk_mem(input string tag, input logic [7:0] a, input logic [7:0] exp);
    i_mem_addr = a;
    #1 chk(tag, 16'(o_mem_data), 16'(exp));
  endtask

  initial begin
    int w;
    logic bad;
    rst_n      = 1'b0;
    i_in_data  = 8'h00;
    i_in_valid = 1'b0;
    i_mem_addr = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy",  16'(o_in_ready),   16'd0);
    chk("rst_core", 16'(o_core_rst_n), 16'd0);
    chk("rst_busy", 16'(o_busy),       16'd0);
    chk("rst_err",  16'(o_err),        16'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_rdy",  16'(o_in_ready),   16'd1);
    chk("idle_core", 16'(o_core_rst_n), 16'd0);

    // 1: basic frame
    send(8'hA5);
    chk("t1_busy", 16'(o_busy), 16'd1);
    send(8'h00); send(8'h03); send(8'hB1); send(8'h10); send(8'hD0);
    send_csum(8'h6C);
    hold_check("t1");
    chk_mem("t1_m0", 8'h00, 8'hB1);
    chk_mem("t1_m1", 8'h01, 8'h10);
    chk_mem("t1_m2", 8'h02, 8'hD0);

`ifdef USEQ_LDR_CSUM_EN
    // 2: bad checksum, then retry
    send(8'hA5); send(8'h00); send(8'h03); send(8'hB1); send(8'h10); send(8'hD0);
    send(8'h6D);
    chk("t2_err",  16'(o_err),        16'd1);
    chk("t2_core", 16'(o_core_rst_n), 16'd0);
    chk("t2_busy", 16'(o_busy),       16'd0);
    send(8'hA5);
    chk("t2_errclr", 16'(o_err), 16'd0);
    send(8'h00); send(8'h03); send(8'hB1); send(8'h10); send(8'hD0);
    send(8'h6C);
    hold_check("t2");
`endif

    // 3: address wrap
    send(8'hA5); send(8'hFE); send(8'h04);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send_csum(8'h54);
    hold_check("t3");
    chk_mem("t3_mFE", 8'hFE, 8'h11);
    chk_mem("t3_mFF", 8'hFF, 8'h22);
    chk_mem("t3_m00", 8'h00, 8'h33);
    chk_mem("t3_m01", 8'h01, 8'h44);
    chk_mem("t3_m02", 8'h02, 8'hD0);

    // 4: LEN=0 full page, sum(0..255)=0x7F80 -> CSUM 0x80
    send(8'hA5); send(8'h00); send(8'h00);
    for (int i = 0; i < 256; i++) send(8'(i));
    send_csum(8'h80);
    hold_check("t4");
    bad = 1'b0;
    for (int i = 0; i < 256; i++) begin
      i_mem_addr = 8'(i);
      #1;
      if (o_mem_data !== 8'(i) && !bad) begin
        bad = 1'b1;
        chk("t4_page", 16'(o_mem_data), 16'(i));
      end
    end
    chk("t4_page_ok", 16'(bad), 16'd0);

    // 5: junk before SYNC is discarded; SYNC held through HOLD waits
    send(8'h00); send(8'hFF); send(8'h5A);
    chk("t5_busy", 16'(o_busy),       16'd0);
    chk("t5_core", 16'(o_core_rst_n), 16'd1);
    chk_mem("t5_m00", 8'h00, 8'h00);
    chk_mem("t5_mFF", 8'hFF, 8'hFF);
    send(8'hA5); send(8'h10); send(8'h01); send(8'h77);
    send_csum(8'h78);
    @(negedge clk);
    i_in_data  = 8'hA5;
    i_in_valid = 1'b1;
    chk("t5_stall_rdy", 16'(o_in_ready), 16'd0);
    w = 0;
    while (!o_in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("t5_hold_len", 16'(w), 16'(BOOT_HOLD));
    chk("t5_rel",      16'(o_core_rst_n), 16'd1);
    @(posedge clk);
    #1 i_in_valid = 1'b0;
    chk("t5_reassert", 16'(o_core_rst_n), 16'd0);
    chk("t5_busy2",    16'(o_busy),       16'd1);
    send(8'h10); send(8'h01); send(8'h77);
    send_csum(8'h78);
    hold_check("t5");
    chk_mem("t5_m10", 8'h10, 8'h77);

    // 6: reset mid-frame after two of three data bytes
    send(8'hA5); send(8'h20); send(8'h03); send(8'hC1); send(8'hC2);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_rst_rdy",  16'(o_in_ready),   16'd0);
    chk("t6_rst_core", 16'(o_core_rst_n), 16'd0);
    rst_n = 1'b1;
    chk("t6_rst_busy", 16'(o_busy), 16'd0);
    chk_mem("t6_m20", 8'h20, 8'hC1);
    chk_mem("t6_m21", 8'h21, 8'hC2);
    send(8'hC3);
    chk("t6_idle", 16'(o_busy), 16'd0);
    send(8'hA5); send(8'h22); send(8'h01); send(8'hC3);
    send_csum(8'h1A);
    hold_check("t6");
    chk_mem("t6_m22", 8'h22, 8'hC3);
    chk_mem("t6_m20b", 8'h20, 8'hC1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
